// File: rtl/dsm_pkg.sv
// Shared types and helpers for the delta-sigma DAC modulator.
package dsm_pkg;

  localparam int ORDER_MIN = 1;
  localparam int ORDER_MAX = 2;

  // Working width of the clamp helper; callers sign-extend into it.
  localparam int SAT_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Signed add clamped to the range of a 'width'-bit two's complement value.
  // Operands must already be small enough that a + b cannot wrap SAT_W bits.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int                      width
  );
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (width - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/dsm_dac_mod_if.sv
// Sample-side handshake bundle: source drives osr/data/valid, DAC returns ready.
interface dsm_dac_mod_if #(
  parameter int DATA_WIDTH = 16,
  parameter int OSR_WIDTH  = 8
);
  logic [OSR_WIDTH-1:0]         osr;
  logic signed [DATA_WIDTH-1:0] data;
  logic                         valid;
  logic                         ready;

  modport master (output osr, output data, output valid, input ready);
  modport slave  (input osr, input data, input valid, output ready);
endinterface

// File: rtl/dsm_sat_integrator.sv
// One saturating integrator stage; flags when the clamp engaged this cycle.
module dsm_sat_integrator
  import dsm_pkg::*;
#(
  parameter int ACC_WIDTH = 20,
  parameter int IN_WIDTH  = 21
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic signed [IN_WIDTH-1:0]  addend,
  output logic signed [ACC_WIDTH-1:0] acc,
  output logic                        sat
);

  logic signed [SAT_W-1:0] acc_ext;
  logic signed [SAT_W-1:0] add_ext;
  logic signed [SAT_W-1:0] raw_sum;
  logic signed [SAT_W-1:0] clamped;

  // Wide sum and its clamped value; sat when the two differ.
  always_comb begin
    acc_ext = {{(SAT_W-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
    add_ext = {{(SAT_W-IN_WIDTH){addend[IN_WIDTH-1]}}, addend};
    raw_sum = acc_ext + add_ext;
    clamped = sat_add(acc_ext, add_ext, ACC_WIDTH);
    sat     = (clamped != raw_sum);
  end

  // Accumulator register, frozen when not enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= clamped[ACC_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/dsm_dac_mod.sv
// 1st/2nd-order delta-sigma DAC modulator with held-sample input register.
//
//   state | meaning
//   IDLE  | no sample accepted since reset; modulator runs on x = 0
//   RUN   | at least one sample accepted; starved cycles flag underrun
module dsm_dac_mod
  import dsm_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ORDER        = 2,
  parameter int OSR_WIDTH    = 8,
  parameter int ACC_WIDTH    = DATA_WIDTH + 4,
  parameter int FEEDBACK_MAG = 1 << (DATA_WIDTH - 1)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  dsm_dac_mod_if.slave smp,
  output logic        o_dac_bitstream,
  output logic        o_underrun,
  output logic        o_overload
);

  if (ORDER < ORDER_MIN || ORDER > ORDER_MAX) begin : g_bad_order
    $error("dsm_dac_mod: ORDER must be 1 or 2");
  end
  if (ACC_WIDTH < DATA_WIDTH + 3) begin : g_bad_acc
    $error("dsm_dac_mod: ACC_WIDTH must be at least DATA_WIDTH+3");
  end

  // One extra bit so acc1 - 2*y never wraps before the clamp sees it.
  localparam int IN_WIDTH = ACC_WIDTH + 1;
  localparam logic signed [IN_WIDTH-1:0] FB = IN_WIDTH'(FEEDBACK_MAG);

  state_e                       state;
  logic signed [DATA_WIDTH-1:0] x_reg;
  logic [OSR_WIDTH-1:0]         cnt;
  logic signed [ACC_WIDTH-1:0]  acc [ORDER];
  logic [ORDER-1:0]             sat;
  logic                         q;
  logic signed [IN_WIDTH-1:0]   y;
  logic                         accept;

  assign q               = ~acc[ORDER-1][ACC_WIDTH-1];
  assign y               = q ? FB : -FB;
  assign o_dac_bitstream = q;
  assign smp.ready       = i_en && (cnt == '0);
  assign accept          = smp.valid && smp.ready;
  assign o_underrun      = !i_rst && i_en && (state == RUN) && (cnt == '0) && !smp.valid;

  for (genvar g = 0; g < ORDER; g++) begin : g_int
    logic signed [IN_WIDTH-1:0] addend;
    if (g == 0) begin : g_first
      assign addend = {{(IN_WIDTH-DATA_WIDTH){x_reg[DATA_WIDTH-1]}}, x_reg} - y;
    end else begin : g_next
      assign addend = {acc[g-1][ACC_WIDTH-1], acc[g-1]} - (y <<< 1);
    end
    dsm_sat_integrator #(
      .ACC_WIDTH (ACC_WIDTH),
      .IN_WIDTH  (IN_WIDTH)
    ) u_int (
      .clk    (i_clk),
      .rst    (i_rst),
      .en     (i_en),
      .addend (addend),
      .acc    (acc[g]),
      .sat    (sat[g])
    );
  end

  // Sample register, oversampling hold counter and idle/run state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      x_reg <= '0;
      cnt   <= '0;
    end else if (i_en) begin
      if (accept) begin
        state <= RUN;
        x_reg <= smp.data;
        cnt   <= (smp.osr == '0) ? '0 : smp.osr - OSR_WIDTH'(1);
      end else if (cnt != '0) begin
        cnt <= cnt - OSR_WIDTH'(1);
      end
    end
  end

  // Overload pulse one cycle after any integrator clamped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_overload <= 1'b0;
    end else begin
      o_overload <= i_en && (|sat);
    end
  end

endmodule
